// File: rtl/alu_arbiter_2p.sv
// Two-port round-robin arbiter in front of a shared 4-bit ALU: IDLE -> EXEC -> RESP per operation.
// Optional per-requester completion counters are enabled with `define ALU_ARB_CNT_EN.
module alu_arbiter_2p (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [2:0] req0_sel,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [2:0] req1_sel,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_zero,
    input  logic       alu_overflow,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_result,
    output logic [2:0] rsp_flags
`ifdef ALU_ARB_CNT_EN
    ,
    output logic [7:0] op_cnt0,
    output logic [7:0] op_cnt1
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state_q, state_d;
    logic       last_q;
    logic       grant_any;
    logic       grant_id;

    // last_q is the requester granted most recently; on contention the other one wins.
    always_comb begin
        grant_id   = req1_valid && (!req0_valid || !last_q);
        grant_any  = !rst && (state_q == IDLE) && (req0_valid || req1_valid);
        req0_ready = grant_any && !grant_id;
        req1_ready = grant_any && grant_id;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_any) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rsp_valid = (state_q == RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_sel    <= 3'd0;
            rsp_id     <= 1'b0;
            rsp_result <= 4'd0;
            rsp_flags  <= 3'd0;
        end else begin
            state_q <= state_d;
            if (grant_any) begin
                last_q  <= grant_id;
                alu_a   <= grant_id ? req1_a   : req0_a;
                alu_b   <= grant_id ? req1_b   : req0_b;
                alu_sel <= grant_id ? req1_sel : req0_sel;
            end
            if (state_q == EXEC) begin
                rsp_id     <= last_q;
                rsp_result <= alu_result;
                rsp_flags  <= {alu_carry, alu_zero, alu_overflow};
            end
        end
    end

`ifdef ALU_ARB_CNT_EN
    logic done;
    assign done = rsp_valid && rsp_ready;

    // Saturating completion counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt0 <= 8'd0;
            op_cnt1 <= 8'd0;
        end else if (done) begin
            if (!rsp_id && op_cnt0 != 8'hff) op_cnt0 <= op_cnt0 + 8'd1;
            if (rsp_id && op_cnt1 != 8'hff)  op_cnt1 <= op_cnt1 + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter_2p.sv
// Self-checking bench for alu_arbiter_2p: directed scenarios plus randomized traffic vs a
// transaction-level model. Counter checks run when ALU_ARB_CNT_EN is defined.
module tb_alu_arbiter_2p;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_sel, req1_sel;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_sel;
    logic       alu_carry, alu_zero, alu_overflow;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [3:0] rsp_result;
    logic [2:0] rsp_flags;
`ifdef ALU_ARB_CNT_EN
    logic [7:0] op_cnt0, op_cnt1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    alu_arbiter_2p dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags)
`ifdef ALU_ARB_CNT_EN
        ,
        .op_cnt0(op_cnt0), .op_cnt1(op_cnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stub(input logic [3:0] r, input logic [2:0] f);
        alu_result = r;
        {alu_carry, alu_zero, alu_overflow} = f;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("ready0_in_reset", {7'd0, req0_ready}, 8'd0);
        check("ready1_in_reset", {7'd0, req1_ready}, 8'd0);
        tick();
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
    endtask

    // Transaction-level reference state
    int         m_phase;          // 0 waiting for grant, 1 operation issued, 2 response held
    int         m_last;
    logic [3:0] m_a, m_b, m_res;
    logic [2:0] m_sel, m_flg;
    logic       m_id;

    initial begin
        rst = 1'b0; rsp_ready = 1'b0;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_sel = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
        stub(4'd0, 3'd0);
        #2;

        // Reset state
        do_reset();
        check("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
        check("rst_rsp_id", {7'd0, rsp_id}, 8'd0);
        check("rst_rsp_result", {4'd0, rsp_result}, 8'd0);
        check("rst_rsp_flags", {5'd0, rsp_flags}, 8'd0);
        check("rst_alu_a", {4'd0, alu_a}, 8'd0);
`ifdef ALU_ARB_CNT_EN
        check("rst_cnt0", op_cnt0, 8'd0);
`endif

        // Single op
        stub(4'b1000, 3'b001);
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'b0101; req0_b = 4'b0011; req0_sel = 3'b000;
        #1;
        check("single_ready0", {7'd0, req0_ready}, 8'd1);
        check("single_ready1", {7'd0, req1_ready}, 8'd0);
        tick();
        req0_valid = 1'b0;
        #1;
        check("single_ready0_exec", {7'd0, req0_ready}, 8'd0);
        check("single_alu_a", {4'd0, alu_a}, 8'b0101);
        check("single_alu_b", {4'd0, alu_b}, 8'b0011);
        check("single_alu_sel", {5'd0, alu_sel}, 8'd0);
        check("single_no_early_valid", {7'd0, rsp_valid}, 8'd0);
        tick();
        check("single_rsp_valid", {7'd0, rsp_valid}, 8'd1);
        check("single_rsp_id", {7'd0, rsp_id}, 8'd0);
        check("single_rsp_result", {4'd0, rsp_result}, 8'b1000);
        check("single_rsp_flags", {5'd0, rsp_flags}, 8'b001);
        tick();
        check("single_done", {7'd0, rsp_valid}, 8'd0);

        // Contention from reset: grants alternate 0,1,0,1
        do_reset();
        stub(4'b0000, 3'b010);
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 4'h3; req1_a = 4'hc;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("cont_ready0", {7'd0, req0_ready}, (k % 2 == 0) ? 8'd1 : 8'd0);
            check("cont_ready1", {7'd0, req1_ready}, (k % 2 == 1) ? 8'd1 : 8'd0);
            tick();
            check("cont_alu_a", {4'd0, alu_a}, (k % 2 == 0) ? 8'h3 : 8'hc);
            check("cont_exec_ready", {6'd0, req0_ready, req1_ready}, 8'd0);
            tick();
            check("cont_rsp_id", {7'd0, rsp_id}, (k % 2 == 1) ? 8'd1 : 8'd0);
            check("cont_rsp_flags", {5'd0, rsp_flags}, 8'b010);
            check("cont_rsp_result", {4'd0, rsp_result}, 8'd0);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Back-pressure (last grant was requester 1, so requester 0 alone is granted)
        stub(4'b0110, 3'b101);
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h2;
        #1;
        check("bp_accept", {7'd0, req0_ready}, 8'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        req1_valid = 1'b1;
        stub(4'b1111, 3'b000);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_valid", {7'd0, rsp_valid}, 8'd1);
            check("bp_result", {4'd0, rsp_result}, 8'b0110);
            check("bp_flags", {5'd0, rsp_flags}, 8'b101);
            check("bp_id", {7'd0, rsp_id}, 8'd0);
            check("bp_readys", {6'd0, req0_ready, req1_ready}, 8'd0);
            tick();
        end
        rsp_ready = 1'b1; req1_valid = 1'b0;
        tick();
        check("bp_complete", {7'd0, rsp_valid}, 8'd0);

        // Withdrawn request while busy
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b1;
        #1;
        check("wd_ready1_exec", {7'd0, req1_ready}, 8'd0);
        tick();
        req1_valid = 1'b0;
        check("wd_resp", {7'd0, rsp_valid}, 8'd1);
        tick();
        #1;
        check("wd_ready1_idle", {7'd0, req1_ready}, 8'd0);
        tick();
        check("wd_no_grant", {7'd0, rsp_valid}, 8'd0);
        tick();
        check("wd_still_idle", {7'd0, rsp_valid}, 8'd0);

        // Reset mid-op (last grant is requester 0 before this)
        stub(4'h9, 3'b111);
        req0_valid = 1'b1; req0_a = 4'h7; req0_b = 4'h6; req0_sel = 3'h5;
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rmid_valid", {7'd0, rsp_valid}, 8'd0);
        check("rmid_result", {4'd0, rsp_result}, 8'd0);
        check("rmid_flags", {5'd0, rsp_flags}, 8'd0);
        check("rmid_alu_a", {4'd0, alu_a}, 8'd0);
        check("rmid_alu_b", {4'd0, alu_b}, 8'd0);
        check("rmid_alu_sel", {5'd0, alu_sel}, 8'd0);
        tick();
        check("rmid_no_rsp", {7'd0, rsp_valid}, 8'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rmid_grant0", {6'd0, req0_ready, req1_ready}, 8'b10);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Randomized traffic against the model
        do_reset();
        m_phase = 0; m_last = 1; m_a = 0; m_b = 0; m_sel = 0;
        m_id = 0; m_res = 0; m_flg = 0;
        for (int c = 0; c < 400; c++) begin
            int w;
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_a = 4'($urandom); req0_b = 4'($urandom); req0_sel = 3'($urandom);
            req1_a = 4'($urandom); req1_b = 4'($urandom); req1_sel = 3'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            stub(4'($urandom), 3'($urandom));
            #1;
            w = -1;
            if (m_phase == 0) begin
                if (req0_valid && req1_valid) w = 1 - m_last;
                else if (req0_valid) w = 0;
                else if (req1_valid) w = 1;
            end
            check("rnd_ready0", {7'd0, req0_ready}, (w == 0) ? 8'd1 : 8'd0);
            check("rnd_ready1", {7'd0, req1_ready}, (w == 1) ? 8'd1 : 8'd0);
            check("rnd_rsp_valid", {7'd0, rsp_valid}, (m_phase == 2) ? 8'd1 : 8'd0);
            check("rnd_alu", {1'b0, alu_sel, alu_a}, {1'b0, m_sel, m_a});
            check("rnd_alu_b", {4'd0, alu_b}, {4'd0, m_b});
            if (m_phase == 2)
                check("rnd_rsp", {rsp_id, rsp_flags, rsp_result}, {m_id, m_flg, m_res});
            case (m_phase)
                0: if (w >= 0) begin
                    m_a   = (w == 1) ? req1_a : req0_a;
                    m_b   = (w == 1) ? req1_b : req0_b;
                    m_sel = (w == 1) ? req1_sel : req0_sel;
                    m_last = w;
                    m_phase = 1;
                end
                1: begin
                    m_id = (m_last == 1);
                    m_res = alu_result;
                    m_flg = {alu_carry, alu_zero, alu_overflow};
                    m_phase = 2;
                end
                default: if (rsp_ready) m_phase = 0;
            endcase
            tick();
        end

`ifdef ALU_ARB_CNT_EN
        // 300 back-to-back req0 ops: 3 cycles each, counter saturates at 255
        do_reset();
        req0_valid = 1'b1; rsp_ready = 1'b1;
        for (int c = 0; c < 762; c++) tick();
        check("cnt0_254", op_cnt0, 8'd254);
        for (int c = 762; c < 900; c++) tick();
        check("cnt0_sat", op_cnt0, 8'd255);
        check("cnt1_zero", op_cnt1, 8'd0);
        req0_valid = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
